// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder. One full-adder cell, built from two half adders
// and an OR for the carry, is reused over WIDTH clock cycles. The LSBs are
// processed first. Operands are accepted through a valid/ready handshake while
// IDLE, and the result is offered through a valid/ready handshake while DONE.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   When this macro is defined, the block gains a 'sub' input.
//   With sub=1, b is loaded inverted and the carry starts at 1, so the block
//   computes a-b. In that case carry_out=1 means no borrow occurred.
//   When the macro is undefined, the block only adds and the carry always
//   starts at 0.

module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  // Controller states. The encoding 2'd3 is illegal and falls back to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carry_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_s;
  logic             w_ha2_c;
  logic             w_bit_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shr;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;

  // Operand conditioning at load time.
  // Subtraction is a + ~b + 1, so invert b and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_init = sub;
`else
  assign w_b_load     = b;
  assign w_carry_init = 1'b0;
`endif

  // Shared full-adder cell: HA1 adds the operand bits, and HA2 adds the
  // stored carry to that partial sum.
  half_adder u_ha1 (
    .i_x (r_a_sh[0]),
    .i_y (r_b_sh[0]),
    .o_s (w_ha1_s),
    .o_c (w_ha1_c)
  );

  half_adder u_ha2 (
    .i_x (w_ha1_s),
    .i_y (r_carry),
    .o_s (w_ha2_s),
    .o_c (w_ha2_c)
  );

  assign w_bit_c = w_ha1_c | w_ha2_c;

  // The new sum bit enters the result register at the MSB end.
  // The LSB-first bits therefore land in place after WIDTH shifts.
  assign w_res_shr = r_res_sh >> 1;
  assign w_res_nxt = w_res_shr | (WIDTH'(w_ha2_s) << (WIDTH - 1));

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state decode. Any illegal encoding returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand shifters, running carry and bit counter.
  // The counter returns to 0 on the last bit, so it never passes WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= w_b_load;
            r_res_sh <= '0;
            r_carry  <= w_carry_init;
            r_cnt    <= '0;
          end else begin
            r_a_sh   <= r_a_sh;
            r_b_sh   <= r_b_sh;
            r_res_sh <= r_res_sh;
            r_carry  <= r_carry;
            r_cnt    <= r_cnt;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_nxt;
          r_carry  <= w_bit_c;
          if (w_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_a_sh   <= r_a_sh;
          r_b_sh   <= r_b_sh;
          r_res_sh <= r_res_sh;
          r_carry  <= r_carry;
          r_cnt    <= r_cnt;
        end
      endcase
    end
  end

  // Result registers.
  // They capture only on the final RUN bit and otherwise hold, so sum and
  // carry_out stay stable through DONE backpressure and afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_sum       <= w_res_nxt;
      r_carry_out <= w_bit_c;
    end else begin
      r_sum       <= r_sum;
      r_carry_out <= r_carry_out;
    end
  end

  // Handshake and status outputs are decoded from the state register only.
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8).
// A cycle-level reference model predicts the handshake, busy and result
// outputs, and a compare process checks the DUT against it on every falling
// edge. Directed operations also check hand-computed literal results.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         sub;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int cmp_count = 0;
  int err_count = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    cmp_count++;
    if (act !== exp_v) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Arithmetic reference: {carry, sum} of a+b, or of a+~b+1 for subtraction.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
  endfunction

  // Reference model.
  // After an accept, the result appears W cycles later and is then held until
  // it is delivered.
  int           m_run_left;
  bit           m_has;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic [W-1:0] m_pend_sum;
  logic         m_pend_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run_left <= 0;
      m_has      <= 1'b0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
    end else if (m_run_left > 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_has  <= 1'b1;
        m_sum  <= m_pend_sum;
        m_cout <= m_pend_c;
      end
    end else if (m_has) begin
      if (out_ready) m_has <= 1'b0;
    end else if (in_valid) begin
      {m_pend_c, m_pend_sum} <= ref_calc(a, b, sub);
      m_run_left <= W;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready",  {31'd0, in_ready},  {31'd0, (m_run_left == 0) && !m_has});
      chk("m_busy",      {31'd0, busy},      {31'd0, (m_run_left > 0)});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_has});
      chk("m_sum",       {24'd0, sum},       {24'd0, m_sum});
      chk("m_carry",     {31'd0, carry_out}, {31'd0, m_cout});
      chk("m_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
    end
  end

  // Run one operation with hand-computed expectations.
  // When hold > 0, out_ready stays low for hold cycles after out_valid rises,
  // and stray in_valid pulses are injected during RUN and DONE.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input logic [W-1:0] esum, input logic ec, input int hold,
                       input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
      if (hold > 0 && n == 2) begin
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({nm, "_latency"}, n, W);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, esum});
    chk({nm, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        a = 8'h77; b = 8'h11; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_hold_sum"}, {24'd0, sum}, {24'd0, esum});
      chk({nm, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_kept_sum"}, {24'd0, sum}, {24'd0, esum});
  endtask

  initial begin
    int n;
    rst = 1'b1; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_sum",       {24'd0, sum},       32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "wrap");
    do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, "alt");
    do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 5, "bp");

    // Reset in the middle of an operation, when the counter is 3.
    a = 8'h55; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum",       {24'd0, sum},       32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_result", {31'd0, out_valid}, 32'd0);
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "after_rst");

    // Back-to-back operations with out_ready tied high and in_valid held high.
    out_ready = 1'b1;
    a = 8'h80; b = 8'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b1_latency", n, W);
    chk("b2b1_sum",   {24'd0, sum},       32'h00);
    chk("b2b1_carry", {31'd0, carry_out}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_gap_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_gap_busy",  {31'd0, busy},     32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b2_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b2_sum",   {24'd0, sum},       32'h03);
    chk("b2b2_carry", {31'd0, carry_out}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, "sub_borrow");
    do_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0, "sub_noborrow");
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "sub0_add");
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller that time-shares one full-adder cell over WIDTH clock cycles.
- The cell is two half_adder instances plus an OR for the carry.
- Sequences operand shifting, carry storage and result assembly.
- Valid/ready handshakes on input and output. Sits between an operand source and a result consumer where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, sampled on input handshake.
- b  input  WIDTH  operand B, sampled on input handshake.
- out_valid  output  1  sum/carry_out are valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result A+B modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN.

Behaviour:
- Reset (async, active-high): state=IDLE; internal regs cleared; sum=0, carry_out=0, out_valid=0, busy=0, in_ready=1 on the first cycle after release.
- Reset asserted mid-RUN or mid-DONE aborts immediately; the partial result is discarded and never presented.
- State IDLE:
  - in_ready=1.
  - At the edge where in_valid&&in_ready: load a_sh=a, b_sh=b, carry=0, cnt=0, res_sh=0; go to RUN.
- State RUN:
  - busy=1, in_ready=0; in_valid is ignored, with no side effects.
  - Each cycle the cell computes s = a_sh[0]^b_sh[0]^carry, c = majority(a_sh[0], b_sh[0], carry) via HA1(a_sh[0], b_sh[0]) and HA2(HA1.s, carry), c = HA1.c|HA2.c.
  - At the edge: a_sh>>=1, b_sh>>=1, res_sh = {s, res_sh[WIDTH-1:1]}, carry=c, cnt++.
  - When cnt==WIDTH-1 at the edge: go to DONE, register sum={s, res_sh[WIDTH-1:1]} and carry_out=c.
- State DONE:
  - out_valid=1; sum and carry_out held stable while out_ready=0 (indefinite backpressure allowed).
  - At the edge where out_valid&&out_ready: go to IDLE; out_valid drops next cycle; sum and carry_out keep their last value.
- Latency: out_valid rises exactly WIDTH cycles after the input-handshake edge.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH run cycles, deliver).
- in_ready and out_valid are never high together; no overlap of operations.
- Counter never exceeds WIDTH-1; no wrap. An illegal state encoding recovers to IDLE.
- All outputs are registered or decoded from state only; no combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds an input port sub (1 bit), sampled on the input handshake.
  - sub=1: b is loaded inverted and carry initialised to 1, giving a-b modulo 2^WIDTH.
  - carry_out=1 means no borrow (a>=b unsigned); carry_out=0 means borrow.
  - sub=0 behaves identically to the undefined build.
- Undefined: no sub port; the block is addition only; carry init is always 0.

Test Plan:
- WIDTH=8, a=0x00, b=0x00 -> out_valid exactly 8 cycles after handshake, sum=0x00, carry_out=0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1; a=0xA5, b=0x5A -> sum=0xFF, carry_out=0.
- Backpressure:
  - Stimulus: a=0x3C, b=0x0F with out_ready low 5 cycles after out_valid.
  - Response: sum=0x4B and out_valid stay stable all 5 cycles; in_ready stays 0; a new in_valid pulse during RUN/DONE is ignored, and the next result reflects only operands accepted in IDLE.
- Reset mid-operation: rst pulsed with cnt=3 -> out_valid=0, sum=0, busy=0 immediately; in_ready=1 after release; a subsequent 0x12+0x34 gives sum=0x46.
- Back-to-back: two ops (0x80+0x80, then 0x01+0x02) with out_ready tied 1 -> results {0x00,c=1} then {0x03,c=0}; second accept is no earlier than 1 cycle after the first delivery.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0.
  - sub=1, a=0x07, b=0x05 -> sum=0x02, carry_out=1.
